// File: rtl/knight_motion_ctrl.sv
// knight_motion_ctrl
// Per-frame player-state engine for the knight sprite. Once per video frame
// it moves the sprite horizontally from the held keys, runs gravity and jumps,
// and advances the walk-animation counter. All state changes happen only on
// the single Clk cycle that follows a synchronised rising edge of frame_clk.
//
// Ports:
//   Clk          system clock
//   Reset_n      asynchronous active-low reset
//   frame_clk    VGA vsync, asynchronous to Clk (synchronised internally)
//   keycode0/1   two held HID keycodes, 0 = none
//   BallX/BallY  sprite centre position
//   Ball_sizeX/Y constant sprite size (30 x 64)
//   BallStatus   0 idle, 1 walk, 2 jump
//   anim_frame   walk sub-frame select
//   facing_left  1 = sprite mirrored
module knight_motion_ctrl #(
  parameter int X_START    = 320,
  parameter int GROUND_Y   = 400,
  parameter int X_MIN      = 15,
  parameter int X_MAX      = 624,
  parameter int Y_MIN      = 32,
  parameter int WALK_SPEED = 2,
  parameter int JUMP_V     = 12,
  parameter int GRAVITY    = 1,
  parameter int MAX_FALL   = 12,
  parameter int ANIM_DIV   = 8,
  parameter logic [7:0] KEY_LEFT  = 8'h04,
  parameter logic [7:0] KEY_RIGHT = 8'h07,
  parameter logic [7:0] KEY_JUMP  = 8'h2C
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic [7:0] keycode0,
  input  logic [7:0] keycode1,
  output logic [9:0] BallX,
  output logic [9:0] BallY,
  output logic [9:0] Ball_sizeX,
  output logic [9:0] Ball_sizeY,
  output logic [3:0] BallStatus,
  output logic       anim_frame,
  output logic       facing_left
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WALK = 2'd1,
    ST_AIR  = 2'd2
  } state_t;

  localparam int CNT_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam int VY_W  = 8;

  localparam logic signed [10:0]   X_MIN_S    = 11'(X_MIN);
  localparam logic signed [10:0]   X_MAX_S    = 11'(X_MAX);
  localparam logic signed [10:0]   X_STEP_S   = 11'(WALK_SPEED);
  localparam logic signed [10:0]   GROUND_Y_S = 11'(GROUND_Y);
  localparam logic signed [10:0]   Y_MIN_S    = 11'(Y_MIN);
  localparam logic signed [VY_W-1:0] VY_JUMP  = VY_W'(-JUMP_V);
  localparam logic signed [VY_W:0]   VY_GRAV  = (VY_W + 1)'(GRAVITY);
  localparam logic signed [VY_W:0]   VY_MAX   = (VY_W + 1)'(MAX_FALL);
  localparam logic [CNT_W-1:0]     CNT_LAST   = CNT_W'(ANIM_DIV - 1);

  // Registers
  logic                   sync1_r, sync2_r, sync3_r;
  state_t                 state_r;
  logic [9:0]             x_r, y_r;
  logic signed [VY_W-1:0] vy_r;
  logic [CNT_W-1:0]       anim_cnt_r;
  logic                   anim_frame_r, facing_r, jump_prev_r;

  // Combinational
  logic                   tick_s;
  logic                   key_l_s, key_r_s, key_j_s;
  logic                   dir_left_s, dir_right_s, moving_s;
  logic                   jump_start_s;
  logic signed [10:0]     x_sum_s;
  logic [9:0]             x_nxt_s;
  logic signed [VY_W-1:0] vy_cur_s;
  logic signed [10:0]     y_sum_s;
  logic signed [VY_W:0]   vy_inc_s;
  logic signed [VY_W-1:0] vy_grav_s;
  state_t                 air_state_s;
  logic [9:0]             air_y_s;
  logic signed [VY_W-1:0] air_vy_s;
  state_t                 state_nxt_s;
  logic [9:0]             y_nxt_s;
  logic signed [VY_W-1:0] vy_nxt_s;
  logic [CNT_W-1:0]       anim_cnt_nxt_s;
  logic                   anim_frame_nxt_s, facing_nxt_s, jump_prev_nxt_s;

  assign tick_s = sync2_r & ~sync3_r;

  assign key_l_s = (keycode0 == KEY_LEFT)  || (keycode1 == KEY_LEFT);
  assign key_r_s = (keycode0 == KEY_RIGHT) || (keycode1 == KEY_RIGHT);
  assign key_j_s = (keycode0 == KEY_JUMP)  || (keycode1 == KEY_JUMP);

  assign dir_left_s  = key_l_s & ~key_r_s;
  assign dir_right_s = key_r_s & ~key_l_s;
  assign moving_s    = dir_left_s | dir_right_s;

  // A jump only launches from the ground on a fresh press seen at a tick.
  assign jump_start_s = (state_r != ST_AIR) && key_j_s && !jump_prev_r;

  // Horizontal step and wall clamp.
  always_comb begin
    x_sum_s = $signed({1'b0, x_r});
    x_nxt_s = x_r;
    if (dir_left_s) begin
      x_sum_s = $signed({1'b0, x_r}) - X_STEP_S;
    end else if (dir_right_s) begin
      x_sum_s = $signed({1'b0, x_r}) + X_STEP_S;
    end else begin
      x_sum_s = $signed({1'b0, x_r});
    end
    if (x_sum_s < X_MIN_S) begin
      x_nxt_s = X_MIN_S[9:0];
    end else if (x_sum_s > X_MAX_S) begin
      x_nxt_s = X_MAX_S[9:0];
    end else begin
      x_nxt_s = x_sum_s[9:0];
    end
  end

  // Airborne vertical step: move by the current speed, then apply gravity,
  // with floor landing and ceiling bounce overriding the speed.
  always_comb begin
    vy_cur_s    = vy_r;
    vy_grav_s   = vy_r;
    air_state_s = ST_AIR;
    air_y_s     = y_r;
    air_vy_s    = vy_r;
    if (jump_start_s) begin
      vy_cur_s = VY_JUMP;
    end else begin
      vy_cur_s = vy_r;
    end
    y_sum_s  = $signed({1'b0, y_r}) + $signed({{(11 - VY_W){vy_cur_s[VY_W-1]}}, vy_cur_s});
    vy_inc_s = $signed({vy_cur_s[VY_W-1], vy_cur_s}) + VY_GRAV;
    if (vy_inc_s > VY_MAX) begin
      vy_grav_s = VY_MAX[VY_W-1:0];
    end else begin
      vy_grav_s = vy_inc_s[VY_W-1:0];
    end
    if (y_sum_s >= GROUND_Y_S) begin
      air_y_s     = GROUND_Y_S[9:0];
      air_vy_s    = '0;
      air_state_s = moving_s ? ST_WALK : ST_IDLE;
    end else if (y_sum_s < Y_MIN_S) begin
      air_y_s     = Y_MIN_S[9:0];
      air_vy_s    = '0;
      air_state_s = ST_AIR;
    end else begin
      air_y_s     = y_sum_s[9:0];
      air_vy_s    = vy_grav_s;
      air_state_s = ST_AIR;
    end
  end

  // Next-state logic for the grounded/airborne state machine.
  always_comb begin
    state_nxt_s = state_r;
    y_nxt_s     = y_r;
    vy_nxt_s    = vy_r;
    if (tick_s) begin
      case (state_r)
        ST_IDLE, ST_WALK: begin
          if (jump_start_s) begin
            state_nxt_s = air_state_s;
            y_nxt_s     = air_y_s;
            vy_nxt_s    = air_vy_s;
          end else begin
            state_nxt_s = moving_s ? ST_WALK : ST_IDLE;
            y_nxt_s     = GROUND_Y_S[9:0];
            vy_nxt_s    = '0;
          end
        end
        ST_AIR: begin
          state_nxt_s = air_state_s;
          y_nxt_s     = air_y_s;
          vy_nxt_s    = air_vy_s;
        end
        default: begin
          state_nxt_s = ST_IDLE;
          y_nxt_s     = GROUND_Y_S[9:0];
          vy_nxt_s    = '0;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
      y_nxt_s     = y_r;
      vy_nxt_s    = vy_r;
    end
  end

  // Walk animation, facing direction and jump-edge memory.
  always_comb begin
    anim_cnt_nxt_s   = anim_cnt_r;
    anim_frame_nxt_s = anim_frame_r;
    facing_nxt_s     = facing_r;
    jump_prev_nxt_s  = jump_prev_r;
    if (tick_s) begin
      jump_prev_nxt_s = key_j_s;
      if (dir_left_s) begin
        facing_nxt_s = 1'b1;
      end else if (dir_right_s) begin
        facing_nxt_s = 1'b0;
      end else begin
        facing_nxt_s = facing_r;
      end
      // Counting keys off the state being entered, so the first walk tick counts.
      if (state_nxt_s == ST_WALK) begin
        if (anim_cnt_r == CNT_LAST) begin
          anim_cnt_nxt_s   = '0;
          anim_frame_nxt_s = ~anim_frame_r;
        end else begin
          anim_cnt_nxt_s   = anim_cnt_r + CNT_W'(1);
          anim_frame_nxt_s = anim_frame_r;
        end
      end else begin
        anim_cnt_nxt_s   = '0;
        anim_frame_nxt_s = 1'b0;
      end
    end else begin
      anim_cnt_nxt_s   = anim_cnt_r;
      anim_frame_nxt_s = anim_frame_r;
      facing_nxt_s     = facing_r;
      jump_prev_nxt_s  = jump_prev_r;
    end
  end

  // frame_clk synchroniser plus edge-detect history.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      sync3_r <= 1'b0;
    end else begin
      sync1_r <= frame_clk;
      sync2_r <= sync1_r;
      sync3_r <= sync2_r;
    end
  end

  // Player state registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r      <= ST_IDLE;
      x_r          <= 10'(X_START);
      y_r          <= 10'(GROUND_Y);
      vy_r         <= '0;
      anim_cnt_r   <= '0;
      anim_frame_r <= 1'b0;
      facing_r     <= 1'b0;
      jump_prev_r  <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      x_r          <= tick_s ? x_nxt_s : x_r;
      y_r          <= y_nxt_s;
      vy_r         <= vy_nxt_s;
      anim_cnt_r   <= anim_cnt_nxt_s;
      anim_frame_r <= anim_frame_nxt_s;
      facing_r     <= facing_nxt_s;
      jump_prev_r  <= jump_prev_nxt_s;
    end
  end

  assign BallX       = x_r;
  assign BallY       = y_r;
  assign Ball_sizeX  = 10'd30;
  assign Ball_sizeY  = 10'd64;
  assign BallStatus  = {2'b00, state_r};
  assign anim_frame  = anim_frame_r;
  assign facing_left = facing_r;

endmodule

// File: tb/tb_knight_motion_ctrl.sv
// Testbench for knight_motion_ctrl: a per-frame player model runs alongside
// the DUT and is compared on every settled cycle; literal expectations pin
// the model at key points (reset, walking, clamps, jump arc, reset mid-jump).
module tb_knight_motion_ctrl;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       frame_clk = 1'b0;
  logic [7:0] keycode0 = 8'h00;
  logic [7:0] keycode1 = 8'h00;
  logic [9:0] BallX, BallY, Ball_sizeX, Ball_sizeY;
  logic [3:0] BallStatus;
  logic       anim_frame, facing_left;

  int checks = 0;
  int errors = 0;

  // Player model state
  int  mx, my, mvy, mst, mcnt, mframe, mface, mjp;
  bit  model_valid = 1'b0;

  knight_motion_ctrl dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk),
    .keycode0(keycode0), .keycode1(keycode1),
    .BallX(BallX), .BallY(BallY), .Ball_sizeX(Ball_sizeX), .Ball_sizeY(Ball_sizeY),
    .BallStatus(BallStatus), .anim_frame(anim_frame), .facing_left(facing_left)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mx = 320; my = 400; mvy = 0; mst = 0; mcnt = 0; mframe = 0; mface = 0; mjp = 0;
  endtask

  // One frame of the game rules applied to the model.
  task automatic model_tick(input logic [7:0] k0, input logic [7:0] k1);
    bit l, r, j;
    int intent, ny;
    l = (k0 == 8'h04) || (k1 == 8'h04);
    r = (k0 == 8'h07) || (k1 == 8'h07);
    j = (k0 == 8'h2C) || (k1 == 8'h2C);
    intent = (l && !r) ? -1 : ((r && !l) ? 1 : 0);
    mx = mx + 2 * intent;
    if (mx < 15) mx = 15;
    if (mx > 624) mx = 624;
    if (intent == -1) mface = 1;
    if (intent == 1) mface = 0;
    if (mst != 2 && j && !mjp) begin
      mst = 2;
      mvy = -12;
    end
    if (mst == 2) begin
      ny = my + mvy;
      mvy = (mvy + 1 > 12) ? 12 : mvy + 1;
      if (ny >= 400) begin
        my = 400; mvy = 0; mst = (intent != 0) ? 1 : 0;
      end else if (ny < 32) begin
        my = 32; mvy = 0;
      end else begin
        my = ny;
      end
    end else begin
      my = 400; mvy = 0; mst = (intent != 0) ? 1 : 0;
    end
    mjp = j ? 1 : 0;
    if (mst == 1) begin
      mcnt++;
      if (mcnt == 8) begin
        mcnt = 0;
        mframe ^= 1;
      end
    end else begin
      mcnt = 0;
      mframe = 0;
    end
  endtask

  // Continuous comparison against the model whenever outputs are settled.
  always @(posedge Clk) begin
    #2;
    if (model_valid && Reset_n) begin
      check("x", int'(BallX), mx);
      check("y", int'(BallY), my);
      check("status", int'(BallStatus), mst);
      check("anim", int'(anim_frame), mframe);
      check("facing", int'(facing_left), mface);
      check("sizex", int'(Ball_sizeX), 30);
      check("sizey", int'(Ball_sizeY), 64);
    end
  end

  // One vsync pulse with the given keys held across it.
  task automatic frame(input logic [7:0] k0, input logic [7:0] k1);
    keycode0 = k0;
    keycode1 = k1;
    model_valid = 1'b0;
    @(negedge Clk);
    frame_clk = 1'b1;
    repeat (4) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (2) @(negedge Clk);
    model_tick(k0, k1);
    model_valid = 1'b1;
    repeat (2) @(negedge Clk);
  endtask

  task automatic lit(input string name, input int x, input int y, input int st);
    check({name, "_x"}, int'(BallX), x);
    check({name, "_y"}, int'(BallY), y);
    check({name, "_st"}, int'(BallStatus), st);
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    lit("reset", 320, 400, 0);
    check("reset_anim", int'(anim_frame), 0);
    check("reset_face", int'(facing_left), 0);
    check("reset_sx", int'(Ball_sizeX), 30);
    check("reset_sy", int'(Ball_sizeY), 64);
    model_valid = 1'b1;

    // Idle frames
    for (int i = 0; i < 3; i++) frame(8'h00, 8'h00);
    lit("idle", 320, 400, 0);

    // Walk right, animation toggles on the eighth tick
    for (int t = 1; t <= 8; t++) begin
      frame(8'h07, 8'h00);
      if (t == 5) begin
        lit("walk5", 330, 400, 1);
        check("walk5_face", int'(facing_left), 0);
      end
      if (t == 7) check("walk7_anim", int'(anim_frame), 0);
      if (t == 8) check("walk8_anim", int'(anim_frame), 1);
    end

    // Walk left into the wall via keycode1
    for (int t = 0; t < 161; t++) frame(8'h00, 8'h04);
    lit("lclamp", 15, 400, 1);
    frame(8'h07, 8'h00);
    lit("x17", 17, 400, 1);
    for (int t = 1; t <= 3; t++) begin
      frame(8'h04, 8'h00);
      check("lclamp_x", int'(BallX), 15);
    end
    check("lclamp_face", int'(facing_left), 1);

    // Walk right into the far wall
    for (int t = 0; t < 305; t++) frame(8'h07, 8'h00);
    lit("rclamp", 624, 400, 1);
    frame(8'h07, 8'h00);
    lit("rclamp2", 624, 400, 1);

    // Both directions cancel
    frame(8'h04, 8'h07);
    frame(8'h07, 8'h04);
    lit("both", 624, 400, 0);
    check("both_anim", int'(anim_frame), 0);

    // Single-tick jump press: full arc
    frame(8'h2C, 8'h00);
    lit("jump1", 624, 388, 2);
    for (int t = 2; t <= 25; t++) begin
      frame(8'h00, 8'h00);
      if (t == 2)  lit("jump2", 624, 377, 2);
      if (t == 12) lit("apex", 624, 322, 2);
      if (t == 24) lit("jump24", 624, 388, 2);
      if (t == 25) lit("land", 624, 400, 0);
    end

    // Held jump key: only one jump
    for (int t = 1; t <= 30; t++) begin
      frame(8'h2C, 8'h00);
      if (t == 1)  lit("held1", 624, 388, 2);
      if (t == 30) lit("held30", 624, 400, 0);
    end
    frame(8'h00, 8'h00);
    lit("release", 624, 400, 0);
    for (int t = 1; t <= 6; t++) frame(8'h2C, 8'h00);
    lit("repress6", 624, 343, 2);

    // Asynchronous reset mid-jump
    @(posedge Clk);
    #3 Reset_n = 1'b0;
    #1;
    lit("midrst", 320, 400, 0);
    check("midrst_face", int'(facing_left), 0);
    check("midrst_anim", int'(anim_frame), 0);
    model_reset();
    @(negedge Clk);
    Reset_n = 1'b1;
    frame(8'h00, 8'h00);
    lit("post_rst", 320, 400, 0);

    // Short vsync glitch between Clk edges is never sampled
    keycode0 = 8'h07;
    @(posedge Clk);
    #1 frame_clk = 1'b1;
    #1 frame_clk = 1'b0;
    repeat (10) @(negedge Clk);
    lit("glitch", 320, 400, 0);
    frame(8'h07, 8'h00);
    lit("after_glitch", 322, 400, 1);

    model_valid = 1'b0;
    repeat (2) @(negedge Clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
